// File: rtl/i2c_arb_pkg.sv
// Shared types and constants for the I2C master arbiter.
package i2c_arb_pkg;

  localparam int DEF_N_REQ    = 4;
  localparam int DEF_START_TO = 64;
  localparam int DEF_XFER_TO  = 200000;

  localparam int ADDR_W = 7;
  localparam int REG_W  = 8;
  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_RUN,
    S_DONE
  } arb_state_e;

  typedef struct packed {
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [REG_W-1:0]  regad;
    logic [DATA_W-1:0] data;
    logic              burst;
  } i2c_cmd_t;

endpackage

// File: rtl/i2c_arbiter_rr_pick.sv
// Round-robin one-hot selector: first requester at or above ptr, wrapping.
module rr_pick
  import i2c_arb_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IW-1:0]    ptr_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [IW-1:0]    idx_o,
  output logic             valid_o
);

  logic [IW:0] k;

  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    k       = '0;
    for (int i = 0; i < N_REQ; i++) begin
      k = {1'b0, ptr_i} + (IW+1)'(i);
      if (k >= (IW+1)'(N_REQ)) begin
        k = k - (IW+1)'(N_REQ);
      end
      if (!valid_o && req_i[k[IW-1:0]]) begin
        valid_o              = 1'b1;
        idx_o                = k[IW-1:0];
        gnt_o[k[IW-1:0]]     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2c_arbiter.sv
// Round-robin arbiter/sequencer sharing one I2C master between requesters,
// with start and transfer timeouts so a hung bus cannot lock others out.
module i2c_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int N_REQ    = DEF_N_REQ,
  parameter int START_TO = DEF_START_TO,
  parameter int XFER_TO  = DEF_XFER_TO
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ-1:0]         req_rw,
  input  logic [ADDR_W*N_REQ-1:0]  req_addr,
  input  logic [REG_W*N_REQ-1:0]   req_reg,
  input  logic [DATA_W*N_REQ-1:0]  req_data,
  input  logic [N_REQ-1:0]         req_burst,
  output logic [N_REQ-1:0]         gnt,
  output logic [N_REQ-1:0]         done,
  output logic [DATA_W-1:0]        rsp_data,
  output logic                     rsp_err,
  output logic                     rsp_timeout,
  output logic                     i2c_en,
  output logic                     i2c_rw,
  output logic                     i2c_burst,
  output logic [ADDR_W-1:0]        i2c_addr,
  output logic [REG_W-1:0]         i2c_reg_addr,
  output logic [DATA_W-1:0]        i2c_data,
  input  logic                     i2c_busy,
  input  logic                     i2c_err,
  input  logic [DATA_W-1:0]        i2c_data_o
);

  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(XFER_TO);
  localparam logic [CW-1:0] START_LAST = CW'(START_TO - 1);
  localparam logic [CW-1:0] XFER_LAST  = CW'(XFER_TO - 1);

  arb_state_e        state_q, state_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic [N_REQ-1:0]  done_q, done_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic [IW-1:0]     win_q, win_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              en_q, en_d;
  i2c_cmd_t          cmd_q, cmd_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rerr_q, rerr_d;
  logic              rto_q, rto_d;

  logic [N_REQ-1:0]  pick_gnt;
  logic [IW-1:0]     pick_idx;
  logic              pick_valid;

  rr_pick #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_pick (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .gnt_o   (pick_gnt),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    ptr_d   = ptr_q;
    win_d   = win_q;
    cnt_d   = cnt_q;
    en_d    = en_q;
    cmd_d   = cmd_q;
    rdata_d = rdata_q;
    rerr_d  = rerr_q;
    rto_d   = rto_q;
    unique case (state_q)
      S_IDLE: begin
        // Bus may still be busy after a transfer timeout.
        if (pick_valid && !i2c_busy) begin
          gnt_d       = pick_gnt;
          win_d       = pick_idx;
          cmd_d.rw    = req_rw[pick_idx];
          cmd_d.addr  = req_addr[pick_idx*ADDR_W +: ADDR_W];
          cmd_d.regad = req_reg[pick_idx*REG_W +: REG_W];
          cmd_d.data  = req_data[pick_idx*DATA_W +: DATA_W];
          cmd_d.burst = req_burst[pick_idx];
          en_d        = 1'b1;
          cnt_d       = '0;
          state_d     = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        if (i2c_busy) begin
          en_d    = 1'b0;
          cnt_d   = '0;
          state_d = S_RUN;
        end else if (cnt_q == START_LAST) begin
          en_d    = 1'b0;
          done_d  = gnt_q;
          rdata_d = '0;
          rerr_d  = 1'b1;
          rto_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RUN: begin
        if (!i2c_busy) begin
          done_d  = gnt_q;
          rdata_d = i2c_data_o;
          rerr_d  = i2c_err;
          rto_d   = 1'b0;
          state_d = S_DONE;
        end else if (cnt_q == XFER_LAST) begin
          done_d  = gnt_q;
          rdata_d = '0;
          rerr_d  = 1'b1;
          rto_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        gnt_d   = '0;
        ptr_d   = (win_q == IW'(N_REQ - 1)) ? '0 : win_q + 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      done_q  <= '0;
      ptr_q   <= '0;
      win_q   <= '0;
      cnt_q   <= '0;
      en_q    <= 1'b0;
      cmd_q   <= '0;
      rdata_q <= '0;
      rerr_q  <= 1'b0;
      rto_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
      cmd_q   <= cmd_d;
      rdata_q <= rdata_d;
      rerr_q  <= rerr_d;
      rto_q   <= rto_d;
    end
  end

  assign gnt          = gnt_q;
  assign done         = done_q;
  assign rsp_data     = rdata_q;
  assign rsp_err      = rerr_q;
  assign rsp_timeout  = rto_q;
  assign i2c_en       = en_q;
  assign i2c_rw       = cmd_q.rw;
  assign i2c_burst    = cmd_q.burst;
  assign i2c_addr     = cmd_q.addr;
  assign i2c_reg_addr = cmd_q.regad;
  assign i2c_data     = cmd_q.data;

endmodule
